// File: rtl/morse_keyer.sv
// -----------------------------------------------------------------------------
// morse_keyer
//
// Purpose:
//   Plays one Morse character per handshake on a single on/off key line.
//   Timing uses Morse units: a dot is 1 unit and a dash is 3 units. Elements
//   are separated by 1 unit and characters by 3 units. A length of 0 is a word
//   space. It adds 4 units to the 3-unit letter gap that has already been sent.
//   Elements are played MSB-first from the low morse_l bits of morse_in.
//
// Parameters:
//   CLKS_PER_UNIT    clock cycles per Morse unit (>= 2)
//   CNT_W            width of the unit-timing counter (2**CNT_W > CLKS_PER_UNIT)
//   TONE_HALF_PERIOD sidetone half period in cycles (sidetone build only)
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   morse_in   element pattern, 1 = dash, 0 = dot; bit 7 is ignored
//   morse_l    element count 0..7; 0 = word space
//   in_valid   morse_in/morse_l are valid
//   in_ready   keyer can accept a character (idle and not in reset)
//   key_out    registered key line, 1 = carrier/LED on
//   busy       character in progress
//   tone_out   square-wave sidetone while keyed (sidetone build only)
//   char_done  one-cycle pulse on the last cycle of a character's trailing gap
//
// Build option:
//   MORSE_KEYER_SIDETONE_EN  adds TONE_HALF_PERIOD and the tone_out sidetone.
// -----------------------------------------------------------------------------
module morse_keyer #(
`ifdef MORSE_KEYER_SIDETONE_EN
  parameter int TONE_HALF_PERIOD = 33750,
`endif
  parameter int CLKS_PER_UNIT = 1620000,
  parameter int CNT_W         = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] morse_in,
  input  logic [2:0] morse_l,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key_out,
  output logic       busy,
`ifdef MORSE_KEYER_SIDETONE_EN
  output logic       tone_out,
`endif
  output logic       char_done
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_UNIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // cycles left in the current unit
  logic [2:0]       unit_q, unit_d;   // units left in the current element/gap
  logic [2:0]       idx_q, idx_d;     // index of the element being played
  logic [2:0]       len_q, len_d;
  logic [6:0]       pat_q, pat_d;
  logic             key_q;

  logic       unit_end, elem_end, take;
  logic [2:0] first_sel, next_sel;
  logic       first_dash, next_dash;
  logic       unused_bit7;

  assign unused_bit7 = morse_in[7];

  assign unit_end = (cnt_q == '0);
  assign elem_end = unit_end && (unit_q == 3'd1);
  assign take     = in_valid && in_ready;

  // Element k is bit len-1-k. At capture, element 0 comes straight from the
  // inputs. While in SPACE, idx_q already points at the upcoming element.
  assign first_sel  = morse_l - 3'd1;
  assign first_dash = morse_in[first_sel];
  assign next_sel   = len_q - 3'd1 - idx_q;
  assign next_dash  = pat_q[next_sel];

  // State and datapath register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. This makes
    // every register update from the values that were present before the edge.
    if (rst) begin
      // NOTE: the captured pattern and length are cleared as well. They are
      // only read after a new capture, but clearing them keeps the whole
      // state known after reset.
      state_q <= IDLE;
      cnt_q   <= '0;
      unit_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      key_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      key_q   <= (state_d == MARK);
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unit_d  = unit_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;

    // All timed states share the unit/cycle countdown.
    if (state_q != IDLE) begin
      cnt_d = unit_end ? RELOAD : cnt_q - CNT_W'(1);
      if (unit_end && (unit_q != 3'd1)) unit_d = unit_q - 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (take) begin
          len_d = morse_l;
          pat_d = morse_in[6:0];
          idx_d = '0;
          cnt_d = RELOAD;
          if (morse_l != 3'd0) begin
            state_d = MARK;
            unit_d  = first_dash ? 3'd3 : 3'd1;
          end else begin
            state_d = GAP;
            unit_d  = 3'd4;
          end
        end
      end
      MARK: begin
        if (elem_end) begin
          if (idx_q != len_q - 3'd1) begin
            state_d = SPACE;
            unit_d  = 3'd1;
            idx_d   = idx_q + 3'd1;
          end else begin
            state_d = GAP;
            unit_d  = 3'd3;
          end
        end
      end
      SPACE: begin
        if (elem_end) begin
          state_d = MARK;
          unit_d  = next_dash ? 3'd3 : 3'd1;
        end
      end
      GAP: begin
        if (elem_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          unit_d  = '0;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    busy      = (state_q != IDLE);
    char_done = (state_q == GAP) && elem_end;
    key_out   = key_q;
  end

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int TONE_W = $clog2(TONE_HALF_PERIOD + 1);

  logic [TONE_W-1:0] tone_cnt_q;
  logic              tone_q;

  // The divider runs only while the key is on. It restarts from zero on each
  // mark, so every mark begins with the same tone phase.
  always_ff @(posedge clk) begin
    if (rst || !key_q) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == TONE_W'(TONE_HALF_PERIOD - 1)) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + TONE_W'(1);
    end
  end

  // Gated with key_q so the tone is low on the first cycle after a mark ends.
  assign tone_out = tone_q && key_q;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// -----------------------------------------------------------------------------
// tb_morse_keyer
//
// Self-checking bench for morse_keyer with CLKS_PER_UNIT=4.
// A reference model turns each accepted character into a queue of expected
// per-cycle slots (key level, char_done). It builds them from the unit rules:
// dot 1, dash 3, element gap 1, letter gap 3, word space 4 more. Each cycle
// pops one slot. An empty queue means idle. Outputs are sampled on the falling
// edge, and new inputs are driven right after sampling.
// Supports MORSE_KEYER_SIDETONE_EN (TONE_HALF_PERIOD=2).
// -----------------------------------------------------------------------------
module tb_morse_keyer;

  localparam int CPU = 4;
`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int THP = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] morse_in;
  logic [2:0] morse_l;
  logic       in_valid;
  logic       in_ready;
  logic       key_out;
  logic       busy;
  logic       char_done;
`ifdef MORSE_KEYER_SIDETONE_EN
  logic       tone_out;
`endif

  always #5 clk = ~clk;

  morse_keyer #(
`ifdef MORSE_KEYER_SIDETONE_EN
    .TONE_HALF_PERIOD(THP),
`endif
    .CLKS_PER_UNIT(CPU),
    .CNT_W(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .morse_in (morse_in),
    .morse_l  (morse_l),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_out  (key_out),
    .busy     (busy),
`ifdef MORSE_KEYER_SIDETONE_EN
    .tone_out (tone_out),
`endif
    .char_done(char_done)
  );

  typedef struct packed {
    logic key;
    logic done;
  } slot_t;

  slot_t exp_q[$];
  int    total   = 0;
  int    bad     = 0;
  int    cyc     = 0;
  int    key_run = 0;
  int    dones   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expand one character into its per-cycle key waveform.
  task automatic push_char(input logic [7:0] pat, input logic [2:0] len);
    int n;
    int gap;
    n = int'(len);
    for (int k = 0; k < n; k++) begin
      int units;
      units = pat[n - 1 - k] ? 3 : 1;
      repeat (units * CPU) exp_q.push_back('{key: 1'b1, done: 1'b0});
      if (k < n - 1) repeat (CPU) exp_q.push_back('{key: 1'b0, done: 1'b0});
    end
    gap = ((n == 0) ? 4 : 3) * CPU;
    repeat (gap - 1) exp_q.push_back('{key: 1'b0, done: 1'b0});
    exp_q.push_back('{key: 1'b0, done: 1'b1});
  endtask

  // One clock cycle: check this cycle's outputs against the model, then drive
  // the inputs for the next edge.
  task automatic step(input logic do_rst, input logic v, input logic [7:0] p,
                      input logic [2:0] l, output logic acc);
    slot_t s;
    logic  eb;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      s  = exp_q.pop_front();
      eb = 1'b1;
    end else begin
      s  = '0;
      eb = 1'b0;
    end
    check("key_out",   32'(key_out),   32'(s.key));
    check("char_done", 32'(char_done), 32'(s.done));
    check("busy",      32'(busy),      32'(eb));
    check("in_ready",  32'(in_ready),  32'(!eb && !rst));
    if (s.done) dones++;
`ifdef MORSE_KEYER_SIDETONE_EN
    key_run = s.key ? key_run + 1 : 0;
    check("tone_out", 32'(tone_out), s.key ? 32'(((key_run - 1) / THP) % 2) : 32'd0);
`endif
    rst      = do_rst;
    in_valid = v;
    morse_in = p;
    morse_l  = l;
    acc      = v && !do_rst && !eb;
    if (do_rst) exp_q.delete();
    else if (acc) push_char(p, l);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 3'd0, acc);
  endtask

  // Hold in_valid until the character is taken, with a bounded wait.
  task automatic send(input logic [7:0] p, input logic [2:0] l);
    logic acc;
    int   waited;
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 200) begin
      step(1'b0, 1'b1, p, l, acc);
      waited++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      idle(1);
      guard++;
    end
    idle(2);
  endtask

  initial begin
    logic acc;
    int   d0;
    rst      = 1'b1;
    in_valid = 1'b0;
    morse_in = 8'h00;
    morse_l  = 3'd0;

    // Reset, then 10 idle cycles with no char_done.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 3'd0, acc);
    idle(10);
    check("idle_no_done", 32'(dones), 32'd0);

    // E, then an immediate word space, then A.
    send(8'h00, 3'd1);
    send(8'h00, 3'd0);
    send(8'h01, 3'd2);
    drain();

    // in_valid held high while the data alternates every cycle, including
    // while the keyer is busy.
    for (int i = 0; i < 150; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 8'h02, 3'd3, acc);
      else            step(1'b0, 1'b1, 8'h05, 3'd4, acc);
    end
    drain();

    // O, reset for one cycle mid-dash, then a fresh T.
    d0 = dones;
    send(8'h07, 3'd3);
    idle(6);
    step(1'b1, 1'b0, 8'h00, 3'd0, acc);
    send(8'h01, 3'd1);
    drain();
    check("reset_abort_done_count", 32'(dones - d0), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       v;
      logic [7:0] p;
      logic [2:0] l;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      p = 8'($urandom);
      l = 3'($urandom_range(0, 7));
      step(r, v, p, l, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
